// File: rtl/voice_mixer.sv
// N-voice stereo mixer. A sample_tick snapshots every voice, then one shared
// gain/pan MAC walks the voices, and a master-gain stage saturates the result.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for sample_tick, outputs holding last frame
// MAC    | voice r_idx enters the gain stage, previous voice accumulates
// DRAIN  | last voice accumulates, nothing new issued
// MASTER | master gain + saturation, outputs and out_valid registered
module voice_mixer #(
   parameter int NUM_VOICES = 8,
   parameter int SAMPLE_W   = 16,
   parameter int GAIN_W     = 16,
   parameter int ACC_W      = SAMPLE_W + 1 + $clog2(NUM_VOICES) + 1
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   input  logic                           sample_tick,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
   input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
   input  logic [NUM_VOICES*16-1:0]       voice_pan,
   input  logic [NUM_VOICES-1:0]          voice_mute,
   input  logic [GAIN_W-1:0]              master_gain,
   output logic signed [SAMPLE_W-1:0]     left_out,
   output logic signed [SAMPLE_W-1:0]     right_out,
   output logic                           out_valid,
   output logic                           clip_l,
   output logic                           clip_r,
   output logic                           busy,
   output logic                           overrun
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int P1W   = SAMPLE_W + GAIN_W + 1;
   localparam int P2W   = SAMPLE_W + 17;
   localparam int PMW   = ACC_W + GAIN_W + 1;

   localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [15:0]                PAN_MAX  = 16'h7FFF;
   localparam logic signed [SAMPLE_W-1:0] S_MAX    = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SAMPLE_W-1:0] S_MIN    = ~S_MAX;
   localparam logic signed [P1W-1:0]      P1_MAX   = P1W'((1 <<< (SAMPLE_W-1)) - 1);
   localparam logic signed [P1W-1:0]      P1_MIN   = ~P1_MAX;
   localparam logic signed [PMW-1:0]      PM_MAX   = PMW'((1 <<< (SAMPLE_W-1)) - 1);
   localparam logic signed [PMW-1:0]      PM_MIN   = ~PM_MAX;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_MASTER} state_t;

   state_t                     r_state;
   logic [IDX_W-1:0]           r_idx;
   logic signed [SAMPLE_W-1:0] r_s_voice [NUM_VOICES];
   logic [GAIN_W-1:0]          r_s_gain  [NUM_VOICES];
   logic [15:0]                r_s_pan   [NUM_VOICES];
   logic [NUM_VOICES-1:0]      r_s_mute;
   logic [GAIN_W-1:0]          r_s_master;
   logic signed [SAMPLE_W-1:0] r_p;
   logic [15:0]                r_p_pan;
   logic                       r_p_vld;
   logic signed [ACC_W-1:0]    r_acc_l;
   logic signed [ACC_W-1:0]    r_acc_r;
   logic                       r_fclip;

   // stage 1: per-voice gain with saturation
   logic signed [SAMPLE_W-1:0] w_v;
   logic [GAIN_W-1:0]          w_g;
   logic [15:0]                w_pan_raw;
   logic [15:0]                w_pan_c;
   logic                       w_mute;
   logic signed [P1W-1:0]      w_s1_prod;
   logic signed [P1W-1:0]      w_s1_shr;
   logic signed [SAMPLE_W-1:0] w_s1_sat;
   logic                       w_s1_clip;

   assign w_v       = r_s_voice[r_idx];
   assign w_g       = r_s_gain[r_idx];
   assign w_pan_raw = r_s_pan[r_idx];
   assign w_mute    = r_s_mute[r_idx];
   assign w_pan_c   = (w_pan_raw > PAN_MAX) ? PAN_MAX : w_pan_raw;
   assign w_s1_prod = P1W'(w_v) * P1W'($signed({1'b0, w_g}));
   assign w_s1_shr  = w_s1_prod >>> 15;

   always_comb begin
      w_s1_clip = 1'b0;
      w_s1_sat  = w_s1_shr[SAMPLE_W-1:0];
      if (w_s1_shr > P1_MAX) begin
         w_s1_clip = 1'b1;
         w_s1_sat  = S_MAX;
      end else if (w_s1_shr < P1_MIN) begin
         w_s1_clip = 1'b1;
         w_s1_sat  = S_MIN;
      end
   end

   // stage 2: pan split into the two accumulators
   logic [15:0]             w_wl;
   logic signed [P2W-1:0]   w_pl;
   logic signed [P2W-1:0]   w_pr;
   logic signed [ACC_W-1:0] w_tl;
   logic signed [ACC_W-1:0] w_tr;

   assign w_wl = PAN_MAX - r_p_pan;
   assign w_pl = P2W'(r_p) * P2W'($signed({1'b0, w_wl}));
   assign w_pr = P2W'(r_p) * P2W'($signed({1'b0, r_p_pan}));
   assign w_tl = ACC_W'(w_pl >>> 15);
   assign w_tr = ACC_W'(w_pr >>> 15);

   // master: returns {clip, saturated sample}
   function automatic logic [SAMPLE_W:0] sat_out(input logic signed [PMW-1:0] x);
      if (x > PM_MAX)
         sat_out = {1'b1, S_MAX};
      else if (x < PM_MIN)
         sat_out = {1'b1, S_MIN};
      else
         sat_out = {1'b0, x[SAMPLE_W-1:0]};
   endfunction

   logic signed [PMW-1:0] w_ml_prod;
   logic signed [PMW-1:0] w_mr_prod;
   logic [SAMPLE_W:0]     w_ol;
   logic [SAMPLE_W:0]     w_or;

   assign w_ml_prod = PMW'(r_acc_l) * PMW'($signed({1'b0, r_s_master}));
   assign w_mr_prod = PMW'(r_acc_r) * PMW'($signed({1'b0, r_s_master}));
   assign w_ol      = sat_out(w_ml_prod >>> 15);
   assign w_or      = sat_out(w_mr_prod >>> 15);

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_s_mute   <= '0;
         r_s_master <= '0;
         r_p        <= '0;
         r_p_pan    <= '0;
         r_p_vld    <= 1'b0;
         r_acc_l    <= '0;
         r_acc_r    <= '0;
         r_fclip    <= 1'b0;
         left_out   <= '0;
         right_out  <= '0;
         out_valid  <= 1'b0;
         clip_l     <= 1'b0;
         clip_r     <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_s_voice[i] <= '0;
            r_s_gain[i]  <= '0;
            r_s_pan[i]   <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         r_p_vld   <= 1'b0;
         if (sample_tick && busy)
            overrun <= 1'b1;
         if (r_p_vld) begin
            r_acc_l <= r_acc_l + w_tl;
            r_acc_r <= r_acc_r + w_tr;
         end
         case (r_state)
            S_IDLE: begin
               if (sample_tick) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     r_s_voice[i] <= voice_in[i*SAMPLE_W +: SAMPLE_W];
                     r_s_gain[i]  <= voice_gain[i*GAIN_W +: GAIN_W];
                     r_s_pan[i]   <= voice_pan[i*16 +: 16];
                  end
                  r_s_mute   <= voice_mute;
                  r_s_master <= master_gain;
                  r_acc_l    <= '0;
                  r_acc_r    <= '0;
                  r_fclip    <= 1'b0;
                  r_idx      <= '0;
                  busy       <= 1'b1;
                  r_state    <= S_MAC;
               end
            end
            S_MAC: begin
               r_p     <= w_mute ? '0 : w_s1_sat;
               r_p_pan <= w_pan_c;
               r_p_vld <= 1'b1;
               if (!w_mute && w_s1_clip)
                  r_fclip <= 1'b1;
               if (r_idx == LAST_IDX)
                  r_state <= S_DRAIN;
               else
                  r_idx <= r_idx + IDX_W'(1);
            end
            S_DRAIN: begin
               r_state <= S_MASTER;
            end
            S_MASTER: begin
               left_out  <= w_ol[SAMPLE_W-1:0];
               right_out <= w_or[SAMPLE_W-1:0];
               clip_l    <= r_fclip | w_ol[SAMPLE_W];
               clip_r    <= r_fclip | w_or[SAMPLE_W];
               out_valid <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
